secded_syndrome_gen: RTL and testbench

SECDED_SYNDROME_GEN -- requirements
Module: secded_syndrome_gen

---
 rtl/secded_syndrome_gen.sv | 159 +++++++++++++++
 tb/tb_secded_syndrome_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/secded_syndrome_gen.sv
// SECDED (39,32)+overall-parity syndrome generator for SRAM read words.
// One registered output stage with valid/ready handshake and saturating error counters.
module secded_syndrome_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [39:0]      in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [39:0]      out_code,
    output logic [6:0]       out_syn,
    output logic             out_single,
    output logic             out_double,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_single,
    output logic [CNT_W-1:0] cnt_double
);

    localparam logic [6:0] H_COL [0:31] = '{
        7'h07, 7'h0B, 7'h13, 7'h23, 7'h43, 7'h0D, 7'h15, 7'h25,
        7'h45, 7'h70, 7'h68, 7'h64, 7'h62, 7'h61, 7'h58, 7'h54,
        7'h52, 7'h51, 7'h0E, 7'h1C, 7'h38, 7'h16, 7'h26, 7'h1A,
        7'h2A, 7'h32, 7'h49, 7'h29, 7'h4A, 7'h19, 7'h4C, 7'h34
    };
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Check bits have unit columns, so they fold straight into the syndrome.
    function automatic logic [6:0] calc_syn(input logic [39:0] code);
        logic [6:0] s;
        s = code[38:32];
        for (int i = 0; i < 32; i++) begin
            s = s ^ ({7{code[i]}} & H_COL[i]);
        end
        return s;
    endfunction

    function automatic logic calc_parity(input logic [39:0] code);
        return ^code;
    endfunction

    function automatic logic in_col_set(input logic [6:0] syn);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < 7; j++) begin
            hit = hit | (syn == (7'd1 << j));
        end
        for (int i = 0; i < 32; i++) begin
            hit = hit | (syn == H_COL[i]);
        end
        return hit;
    endfunction

    logic             out_valid_q,  out_valid_d;
    logic [39:0]      out_code_q,   out_code_d;
    logic [6:0]       out_syn_q,    out_syn_d;
    logic             out_single_q, out_single_d;
    logic             out_double_q, out_double_d;
    logic [CNT_W-1:0] cnt_single_q, cnt_single_d;
    logic [CNT_W-1:0] cnt_double_q, cnt_double_d;

    logic [6:0] syn_s;
    logic       par_s;
    logic       single_s;
    logic       double_s;
    logic       accept_s;
    logic       deliver_s;

    assign in_ready   = !out_valid_q || out_ready;
    assign accept_s   = in_valid && in_ready;
    assign deliver_s  = out_valid_q && out_ready;

    // Decode the incoming word into syndrome and error class.
    always_comb begin
        syn_s    = calc_syn(in_code);
        par_s    = calc_parity(in_code);
        single_s = 1'b0;
        double_s = 1'b0;
        if (syn_s == 7'd0) begin
            single_s = par_s;
        end else if (par_s && in_col_set(syn_s)) begin
            single_s = 1'b1;
        end else begin
            double_s = 1'b1;
        end
    end

    // Next-state for the output stage and the error counters.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_code_d   = out_code_q;
        out_syn_d    = out_syn_q;
        out_single_d = out_single_q;
        out_double_d = out_double_q;
        cnt_single_d = cnt_single_q;
        cnt_double_d = cnt_double_q;

        if (accept_s) begin
            out_valid_d  = 1'b1;
            out_code_d   = in_code;
            out_syn_d    = syn_s;
            out_single_d = single_s;
            out_double_d = double_s;
        end else if (deliver_s) begin
            out_valid_d  = 1'b0;
        end else begin
            out_valid_d  = out_valid_q;
        end

        if (cnt_clr) begin
            cnt_single_d = {CNT_W{1'b0}};
            cnt_double_d = {CNT_W{1'b0}};
        end else begin
            if (deliver_s && out_single_q && (cnt_single_q != CNT_MAX)) begin
                cnt_single_d = cnt_single_q + CNT_ONE;
            end else begin
                cnt_single_d = cnt_single_q;
            end
            if (deliver_s && out_double_q && (cnt_double_q != CNT_MAX)) begin
                cnt_double_d = cnt_double_q + CNT_ONE;
            end else begin
                cnt_double_d = cnt_double_q;
            end
        end
    end

    // State registers; reset wins over any accept, delivery or clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_code_q   <= 40'd0;
            out_syn_q    <= 7'd0;
            out_single_q <= 1'b0;
            out_double_q <= 1'b0;
            cnt_single_q <= {CNT_W{1'b0}};
            cnt_double_q <= {CNT_W{1'b0}};
        end else begin
            out_valid_q  <= out_valid_d;
            out_code_q   <= out_code_d;
            out_syn_q    <= out_syn_d;
            out_single_q <= out_single_d;
            out_double_q <= out_double_d;
            cnt_single_q <= cnt_single_d;
            cnt_double_q <= cnt_double_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_code   = out_code_q;
    assign out_syn    = out_syn_q;
    assign out_single = out_single_q;
    assign out_double = out_double_q;
    assign cnt_single = cnt_single_q;
    assign cnt_double = cnt_double_q;

endmodule

// File: tb/tb_secded_syndrome_gen.sv
// Bench for secded_syndrome_gen: cycle reference model plus directed literal checks.
module tb_secded_syndrome_gen;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [39:0]   in_code;
    logic          out_valid;
    logic          out_ready;
    logic [39:0]   out_code;
    logic [6:0]    out_syn;
    logic          out_single;
    logic          out_double;
    logic          cnt_clr;
    logic [CW-1:0] cnt_single;
    logic [CW-1:0] cnt_double;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    secded_syndrome_gen #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_syn(out_syn), .out_single(out_single), .out_double(out_double),
        .cnt_clr(cnt_clr), .cnt_single(cnt_single), .cnt_double(cnt_double)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] COLS [0:31] = '{
        7'h07, 7'h0B, 7'h13, 7'h23, 7'h43, 7'h0D, 7'h15, 7'h25,
        7'h45, 7'h70, 7'h68, 7'h64, 7'h62, 7'h61, 7'h58, 7'h54,
        7'h52, 7'h51, 7'h0E, 7'h1C, 7'h38, 7'h16, 7'h26, 7'h1A,
        7'h2A, 7'h32, 7'h49, 7'h29, 7'h4A, 7'h19, 7'h4C, 7'h34
    };

    function automatic logic [6:0] col_of(input int i);
        if (i < 32) return COLS[i];
        return 7'(1 << (i - 32));
    endfunction

    function automatic logic [6:0] m_syn(input logic [39:0] c);
        logic [6:0] s = 7'd0;
        for (int i = 0; i < 39; i++) if (c[i]) s ^= col_of(i);
        return s;
    endfunction

    function automatic logic [1:0] m_class(input logic [39:0] c);
        logic [6:0] s = m_syn(c);
        logic p = ^c;
        bit in_set = 1'b0;
        for (int i = 0; i < 39; i++) if (col_of(i) == s) in_set = 1'b1;
        if (s == 7'd0) return p ? 2'b01 : 2'b00;     // {double, single}
        if (p && in_set) return 2'b01;
        return 2'b10;
    endfunction

    // Reference model state
    logic          mv;
    logic [39:0]   mcode;
    logic [6:0]    msyn;
    logic          ms, md;
    int            mcs, mcd;

    always @(posedge clk) begin
        if (rst) begin
            mv <= 1'b0; mcode <= 40'd0; msyn <= 7'd0; ms <= 1'b0; md <= 1'b0;
            mcs <= 0; mcd <= 0;
        end else begin
            if (in_valid && (!mv || out_ready)) begin
                mv <= 1'b1; mcode <= in_code; msyn <= m_syn(in_code);
                ms <= m_class(in_code)[0]; md <= m_class(in_code)[1];
            end else if (mv && out_ready) begin
                mv <= 1'b0;
            end
            if (cnt_clr) begin
                mcs <= 0; mcd <= 0;
            end else begin
                if (mv && out_ready && ms && mcs < 3) mcs <= mcs + 1;
                if (mv && out_ready && md && mcd < 3) mcd <= mcd + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("out_valid", 64'(out_valid), 64'(mv));
            chk("in_ready", 64'(in_ready), 64'(!mv || out_ready));
            chk("cnt_single", 64'(cnt_single), 64'(mcs));
            chk("cnt_double", 64'(cnt_double), 64'(mcd));
            if (mv) begin
                chk("out_code", 64'(out_code), 64'(mcode));
                chk("out_syn", 64'(out_syn), 64'(msyn));
                chk("out_single", 64'(out_single), 64'(ms));
                chk("out_double", 64'(out_double), 64'(md));
                chk("flags_exclusive", 64'(out_single & out_double), 64'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [39:0] held;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_code = 40'd0; out_ready = 1'b0; cnt_clr = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_cnt_single", 64'(cnt_single), 64'd0);
        check_en = 1'b1;

        // Model pins
        chk("model_syn_bit5", 64'(m_syn(40'h20)), 64'h0D);
        chk("model_syn_bits01", 64'(m_syn(40'h3)), 64'h0C);
        chk("model_class_bit39", 64'(m_class(40'h80_0000_0000)), 64'd1);

        // Clean word
        in_valid = 1'b1; in_code = 40'd0; out_ready = 1'b1;
        cyc();
        chk("clean_valid", 64'(out_valid), 64'd1);
        chk("clean_syn", 64'(out_syn), 64'd0);
        chk("clean_flags", 64'({out_double, out_single}), 64'd0);
        // Data bit 5
        in_code = 40'h20;
        cyc();
        chk("bit5_syn", 64'(out_syn), 64'h0D);
        chk("bit5_single", 64'(out_single), 64'd1);
        // Bit 39
        in_code = 40'h80_0000_0000;
        cyc();
        chk("bit5_delivered_cnt", 64'(cnt_single), 64'd1);
        chk("bit39_syn", 64'(out_syn), 64'd0);
        chk("bit39_single", 64'(out_single), 64'd1);
        // Bits 0 and 1
        in_code = 40'h3;
        cyc();
        chk("dbl_syn", 64'(out_syn), 64'h0C);
        chk("dbl_double", 64'(out_double), 64'd1);
        in_valid = 1'b0;
        cyc();
        chk("dbl_cnt", 64'(cnt_double), 64'd1);
        chk("cnt_single_after3", 64'(cnt_single), 64'd2);
        cyc();

        // Backpressure
        cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_code = 40'h12_3456_789A;
        cyc();
        held = out_code;
        chk("bp_first_code", 64'(held), 64'h12_3456_789A);
        in_code = 40'h00_0000_0040;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_stable", 64'(out_code), 64'(held));
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            in_code = 40'(k) << (k * 4);
        end
        in_valid = 1'b0;
        cyc(); cyc();

        // Saturation and clear
        cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
        in_valid = 1'b1; in_code = 40'h20;
        repeat (5) cyc();
        in_valid = 1'b0;
        cyc(); cyc();
        chk("sat_cnt_single", 64'(cnt_single), 64'd3);
        in_valid = 1'b1; in_code = 40'h20; out_ready = 1'b0;
        cyc();
        in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        chk("clr_override", 64'(cnt_single), 64'd0);

        // Short pseudo-random stream with random backpressure
        for (int k = 0; k < 40; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_code   = 40'(1) << $urandom_range(0, 39);
            if ($urandom_range(0, 3) == 0) in_code ^= 40'(1) << $urandom_range(0, 39);
            cyc();
        end

        // Reset during a stall
        in_valid = 1'b1; in_code = 40'h3; out_ready = 1'b0;
        cyc();
        in_valid = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_stall_valid", 64'(out_valid), 64'd0);
        chk("rst_stall_ready", 64'(in_ready), 64'd1);
        chk("rst_stall_cnt", 64'({cnt_single, cnt_double}), 64'd0);
        chk("rst_stall_code", 64'(out_code), 64'd0);
        cyc(); cyc();

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
